// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex matrix keypad scanner with sweep-level debounce.
// Strobes one active-low column at a time, samples synchronized rows on the last
// dwell cycle of each column, reduces each full sweep to NONE / ONE(code) / MULTI
// and runs a press/release debounce FSM once per sweep.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_SCANS sweeps while a key stays held.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_REL_DB
    } state_t;

    // Map of sample index (row*4 + col) to the printed key legend.
    function automatic logic [3:0] f_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col_idx;
    logic [15:0]   r_samples;

    logic          w_dwell_last;
    logic          w_sweep_end;
    logic [15:0]   w_sweep_samples;
    logic [1:0]    w_hit_cnt;
    logic [3:0]    w_hit_idx;
    logic          w_one;
    logic [3:0]    w_hit_code;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cand;
    logic [3:0]    w_cand_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [3:0]    r_code;
    logic [3:0]    w_code_next;
    logic          r_valid;
    logic          w_valid_next;
    logic          r_held;
    logic          w_held_next;
    logic          w_accept;
    logic          w_release;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_next;
`endif

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    assign w_dwell_last = (r_dwell == DW'(SCAN_CYCLES - 1));
    assign w_sweep_end  = w_dwell_last && (r_col_idx == 2'd3);

    // Dwell counter and column index; the scan free-runs forever.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dwell   <= '0;
            r_col_idx <= 2'd0;
        end else if (w_dwell_last) begin
            r_dwell   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_dwell   <= r_dwell + DW'(1);
        end
    end

    assign col = ~(4'b0001 << r_col_idx);

    // Samples of the sweep so far, with the column finishing this cycle merged in live,
    // so the sweep-end reduction sees all 16 positions in the same cycle.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sample
            assign w_sweep_samples[gi] = (w_dwell_last && (r_col_idx == 2'(gi % 4)))
                                         ? ~r_sync2[gi / 4] : r_samples[gi];
        end
    endgenerate

    // Latch each column's row pattern at the end of its dwell.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_samples <= '0;
        end else if (w_dwell_last) begin
            r_samples <= w_sweep_samples;
        end
    end

    // Reduce the sweep to a key count (saturating at 2 = MULTI) and the index of a hit.
    always_comb begin
        w_hit_cnt = 2'd0;
        w_hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_sweep_samples[i]) begin
                if (w_hit_cnt != 2'd2) begin
                    w_hit_cnt = w_hit_cnt + 2'd1;
                end
                w_hit_idx = 4'(i);
            end
        end
    end

    assign w_one      = (w_hit_cnt == 2'd1);
    assign w_hit_code = f_code(w_hit_idx);

    // Debounce FSM state and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= '0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
            r_code  <= w_code_next;
            r_valid <= w_valid_next;
            r_held  <= w_held_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep   <= w_rep_next;
`endif
        end
    end

    // Next-state logic, evaluated only at the end of a sweep; MULTI behaves like NONE.
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_code_next  = r_code;
        w_valid_next = 1'b0;
        w_held_next  = r_held;
        w_accept     = 1'b0;
        w_release    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_next   = r_rep;
`endif
        if (w_sweep_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_one) begin
                        w_cand_next = w_hit_code;
                        w_cnt_next  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_state_next = S_PRESS_DB;
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (!w_one) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else if (w_hit_code == r_cand) begin
                        w_cnt_next = r_cnt + CW'(1);
                        if (int'(r_cnt) + 1 >= DEBOUNCE_SCANS) begin
                            w_accept = 1'b1;
                        end
                    end else begin
                        w_cand_next = w_hit_code;
                        w_cnt_next  = CW'(1);
                    end
                end
                S_PRESSED: begin
                    if (w_one && (w_hit_code == r_cand)) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (int'(r_rep) + 1 >= REPEAT_SCANS) begin
                            w_valid_next = 1'b1;
                            w_rep_next   = '0;
                        end else begin
                            w_rep_next = r_rep + RW'(1);
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        w_release = 1'b1;
                    end else begin
                        w_cnt_next   = CW'(1);
                        w_state_next = S_REL_DB;
                    end
                end
                S_REL_DB: begin
                    if (w_one && (w_hit_code == r_cand)) begin
                        // Bounce during release: key is still down, no new strobe.
                        w_state_next = S_PRESSED;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                        if (int'(r_cnt) + 1 >= DEBOUNCE_SCANS) begin
                            w_release = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        if (w_accept) begin
            w_code_next  = w_cand_next;
            w_valid_next = 1'b1;
            w_held_next  = 1'b1;
            w_state_next = S_PRESSED;
            w_cnt_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_next   = '0;
`endif
        end
        if (w_release) begin
            w_held_next  = 1'b0;
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_next   = '0;
`endif
        end
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad (rows follow the DUT's column
// drive) and compares sweep-by-sweep outputs against a key-event reference model.
module tb_keypad_scanner;

    localparam int SCAN  = 8;
    localparam int DB    = 2;
    localparam int REP   = 3;
    localparam int SWEEP = 4 * SCAN;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed_mask;
    logic [3:0]  keymap [16];

    int checks = 0;
    int errors = 0;

    // Reference model state (key-event level)
    bit         m_held;
    logic [3:0] m_cand;
    logic [3:0] exp_code;
    int         m_cnt;
    int         m_rep;
    bit         m_strobe;

    // Observations from the last sweep
    int sw_mid_valid;
    bit sw_end_valid;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES   (SCAN),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed_mask[r*4 +: 4] & ~col);
        end
    end

    task automatic model_reset();
        m_held   = 0;
        m_cand   = 4'd0;
        exp_code = 4'd0;
        m_cnt    = 0;
        m_rep    = 0;
        m_strobe = 0;
    endtask

    // One sweep of the keypad as the specification describes it, in terms of
    // "is a key held", "how many matching sweeps so far" and the candidate key.
    task automatic model_sweep(input logic [15:0] mask);
        int         n;
        int         idx;
        logic [3:0] k;
        bit         one;
        n   = $countones(mask);
        idx = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
        k   = keymap[idx];
        one = (n == 1);
        m_strobe = 0;
        if (!m_held) begin
            if (one) begin
                if (m_cnt > 0 && k == m_cand) m_cnt++;
                else begin
                    m_cand = k;
                    m_cnt  = 1;
                end
                if (m_cnt >= DB) begin
                    exp_code = m_cand;
                    m_strobe = 1;
                    m_held   = 1;
                    m_cnt    = 0;
                    m_rep    = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end else begin
            if (one && k == m_cand) begin
                if (m_cnt == 0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin
                        m_strobe = 1;
                        m_rep    = 0;
                    end
`endif
                end else begin
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt >= DB) begin
                    m_held = 0;
                    m_cnt  = 0;
                    m_rep  = 0;
                end
            end
        end
    endtask

    // Hold a key pattern for one full sweep; ends at the first cycle of the next sweep.
    task automatic run_sweep(input logic [15:0] mask);
        pressed_mask = mask;
        sw_mid_valid = 0;
        sw_end_valid = 0;
        for (int i = 1; i <= SWEEP; i++) begin
            @(posedge clk);
            #1;
            if (i < SWEEP) begin
                if (key_valid === 1'b1) sw_mid_valid++;
            end else begin
                sw_end_valid = (key_valid === 1'b1);
            end
        end
        model_sweep(mask);
    endtask

    task automatic test_reset();
        logic [3:0] one_hot;
        logic [3:0] exp_col;
        one_hot      = 4'b0001;
        reset        = 1'b0;
        pressed_mask = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        checks += 4;
        if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", col); end
        if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got=%b exp=0", key_held); end
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * SWEEP; i++) begin
            exp_col = ~(one_hot << ((i % SWEEP) / SCAN));
            checks += 2;
            if (col !== exp_col) begin errors++; $display("FAIL scan_col cyc=%0d got=%b exp=%b", i, col, exp_col); end
            if (key_valid !== 1'b0) begin errors++; $display("FAIL scan_idle_valid cyc=%0d got=%b exp=0", i, key_valid); end
            @(posedge clk);
            #1;
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single_key();
        int strobes = 0;
        int exp_strobes;
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_strobes = 3;
`else
        exp_strobes = 1;
`endif
        for (int s = 0; s < 13; s++) begin
            run_sweep(s < 10 ? 16'h0020 : 16'h0000);
            strobes += sw_mid_valid + int'(sw_end_valid);
            checks += 4;
            if (sw_mid_valid != 0) begin errors++; $display("FAIL key5_mid_valid sweep=%0d got=%0d exp=0", s, sw_mid_valid); end
            if (sw_end_valid != m_strobe) begin errors++; $display("FAIL key5_valid sweep=%0d got=%0d exp=%0d", s, sw_end_valid, m_strobe); end
            if (key_code !== exp_code) begin errors++; $display("FAIL key5_code sweep=%0d got=%h exp=%h", s, key_code, exp_code); end
            if (key_held !== m_held) begin errors++; $display("FAIL key5_held sweep=%0d got=%b exp=%b", s, key_held, m_held); end
        end
        checks++;
        if (strobes != exp_strobes) begin errors++; $display("FAIL key5_strobes got=%0d exp=%0d", strobes, exp_strobes); end
        $display("test_single_key done: strobes=%0d code=%h", strobes, key_code);
    endtask

    task automatic test_bounce();
        int strobes = 0;
        for (int s = 0; s < 14; s++) begin
            run_sweep((s < 12 && s % 2 == 0) ? 16'h0100 : 16'h0000);
            strobes += sw_mid_valid + int'(sw_end_valid);
            checks += 3;
            if (sw_end_valid != m_strobe) begin errors++; $display("FAIL bounce_valid sweep=%0d got=%0d exp=%0d", s, sw_end_valid, m_strobe); end
            if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held sweep=%0d got=%b exp=0", s, key_held); end
            if (key_code !== exp_code) begin errors++; $display("FAIL bounce_code sweep=%0d got=%h exp=%h", s, key_code, exp_code); end
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL bounce_strobes got=%0d exp=0", strobes); end
        $display("test_bounce done: strobes=%0d", strobes);
    endtask

    task automatic test_multi();
        int strobes = 0;
        logic [3:0] code_before;
        code_before = exp_code;
        for (int s = 0; s < 8; s++) begin
            run_sweep(s < 6 ? 16'h8001 : 16'h0000);
            strobes += sw_mid_valid + int'(sw_end_valid);
            checks += 3;
            if (key_code !== code_before) begin errors++; $display("FAIL multi_code sweep=%0d got=%h exp=%h", s, key_code, code_before); end
            if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held sweep=%0d got=%b exp=0", s, key_held); end
            if (sw_end_valid != m_strobe) begin errors++; $display("FAIL multi_valid sweep=%0d got=%0d exp=%0d", s, sw_end_valid, m_strobe); end
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL multi_strobes got=%0d exp=0", strobes); end
        $display("test_multi done: strobes=%0d code=%h", strobes, key_code);
    endtask

    task automatic test_reset_held();
        int strobes = 0;
        for (int s = 0; s < 2; s++) run_sweep(16'h0008);
        checks += 2;
        if (key_held !== 1'b1) begin errors++; $display("FAIL keyA_held_before_reset got=%b exp=1", key_held); end
        if (key_code !== 4'hA) begin errors++; $display("FAIL keyA_code_before_reset got=%h exp=a", key_code); end
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks += 4;
        if (col !== 4'b1110) begin errors++; $display("FAIL rst_held_col got=%b exp=1110", col); end
        if (key_code !== 4'h0) begin errors++; $display("FAIL rst_held_code got=%h exp=0", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_held_valid got=%b exp=0", key_valid); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held_held got=%b exp=0", key_held); end
        reset = 1'b1;
        model_reset();
        for (int s = 0; s < 5; s++) begin
            run_sweep(s < 2 ? 16'h0008 : 16'h0000);
            strobes += sw_mid_valid + int'(sw_end_valid);
            checks += 3;
            if (sw_end_valid != m_strobe) begin errors++; $display("FAIL keyA_valid sweep=%0d got=%0d exp=%0d", s, sw_end_valid, m_strobe); end
            if (key_code !== exp_code) begin errors++; $display("FAIL keyA_code sweep=%0d got=%h exp=%h", s, key_code, exp_code); end
            if (key_held !== m_held) begin errors++; $display("FAIL keyA_held sweep=%0d got=%b exp=%b", s, key_held, m_held); end
        end
        checks++;
        if (strobes != 1) begin errors++; $display("FAIL keyA_strobes got=%0d exp=1", strobes); end
        $display("test_reset_held done: strobes=%0d", strobes);
    endtask

    task automatic test_autorepeat();
        int strobes = 0;
        int exp_strobes;
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_strobes = 4;
`else
        exp_strobes = 1;
`endif
        for (int s = 0; s < 15; s++) begin
            run_sweep(s < 12 ? 16'h2000 : 16'h0000);
            strobes += sw_mid_valid + int'(sw_end_valid);
            checks += 3;
            if (sw_end_valid != m_strobe) begin errors++; $display("FAIL keyF_valid sweep=%0d got=%0d exp=%0d", s, sw_end_valid, m_strobe); end
            if (key_code !== exp_code) begin errors++; $display("FAIL keyF_code sweep=%0d got=%h exp=%h", s, key_code, exp_code); end
            if (key_held !== m_held) begin errors++; $display("FAIL keyF_held sweep=%0d got=%b exp=%b", s, key_held, m_held); end
        end
        checks++;
        if (strobes != exp_strobes) begin errors++; $display("FAIL keyF_strobes got=%0d exp=%0d", strobes, exp_strobes); end
        $display("test_autorepeat done: strobes=%0d", strobes);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int kind;
        int len;
        int a;
        int b;
        for (int seg = 0; seg < 25; seg++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 4);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            mask = 16'h0000;
            if (kind == 1 || kind == 3) mask[a] = 1'b1;
            if (kind == 2) begin
                mask[a] = 1'b1;
                mask[b] = 1'b1;
            end
            for (int s = 0; s < len; s++) begin
                run_sweep(mask);
                checks += 4;
                if (sw_mid_valid != 0) begin errors++; $display("FAIL rnd_mid_valid seg=%0d got=%0d exp=0", seg, sw_mid_valid); end
                if (sw_end_valid != m_strobe) begin errors++; $display("FAIL rnd_valid seg=%0d mask=%h got=%0d exp=%0d", seg, mask, sw_end_valid, m_strobe); end
                if (key_code !== exp_code) begin errors++; $display("FAIL rnd_code seg=%0d mask=%h got=%h exp=%h", seg, mask, key_code, exp_code); end
                if (key_held !== m_held) begin errors++; $display("FAIL rnd_held seg=%0d mask=%h got=%b exp=%b", seg, mask, key_held, m_held); end
            end
            $display("random seg=%0d mask=%h sweeps=%0d code=%h held=%b", seg, mask, len, key_code, key_held);
        end
    endtask

    initial begin
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'h0, 4'hF, 4'hE, 4'hD};
        reset        = 1'b0;
        pressed_mask = 16'h0000;
        model_reset();
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_reset_held();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
